ahb_slave_interface: RTL and testbench

- AHB-side slave front end of an AHB-to-APB bridge.
- Registers the incoming AHB address, write data and direction in a two-stage pipeline.
- Qualifies each transfer as valid or not.
- Decodes the address into a one-hot peripheral select for the downstream APB bridge FSM.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/bridge_addr_decode.sv | 20 ++
 rtl/ahb_slave_interface.sv | 62 ++++++
 tb/tb_ahb_slave_interface.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants for the AHB-to-APB bridge: transfer codes, peripheral address map
// and one-hot select encodings.
package bridge_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned SelWidth  = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Three contiguous 64 MiB peripheral windows; SLV_END is exclusive.
  localparam logic [AddrWidth-1:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [AddrWidth-1:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [AddrWidth-1:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [AddrWidth-1:0] SLV_END   = 32'h8C00_0000;

  localparam logic [SelWidth-1:0] SEL_NONE = 3'b000;
  localparam logic [SelWidth-1:0] SEL_SLV0 = 3'b001;
  localparam logic [SelWidth-1:0] SEL_SLV1 = 3'b010;
  localparam logic [SelWidth-1:0] SEL_SLV2 = 3'b100;

endpackage

// File: rtl/bridge_addr_decode.sv
// Address-to-peripheral decoder: maps an AHB address onto a one-hot APB select.
module bridge_addr_decode
  import bridge_pkg::*;
(
  input  logic [AddrWidth-1:0] i_haddr,
  output logic [SelWidth-1:0]  o_sel
);

  always_comb begin
    o_sel = SEL_NONE;
    if (i_haddr >= SLV0_BASE && i_haddr < SLV1_BASE) begin
      o_sel = SEL_SLV0;
    end else if (i_haddr >= SLV1_BASE && i_haddr < SLV2_BASE) begin
      o_sel = SEL_SLV1;
    end else if (i_haddr >= SLV2_BASE && i_haddr < SLV_END) begin
      o_sel = SEL_SLV2;
    end
  end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: two-stage address/data pipeline,
// transfer qualification and peripheral select decode.
module ahb_slave_interface
  import bridge_pkg::*;
(
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hwrite,
  input  logic                 hready_in,
  input  logic [1:0]           htrans,
  input  logic [AddrWidth-1:0] haddr,
  input  logic [DataWidth-1:0] hwdata,
  output logic                 valid,
  output logic [AddrWidth-1:0] haddr_0,
  output logic [AddrWidth-1:0] haddr_1,
  output logic [DataWidth-1:0] hwdata_0,
  output logic [DataWidth-1:0] hwdata_1,
  output logic                 hwrite_reg,
  output logic [SelWidth-1:0]  temp_sel
);

  logic [AddrWidth-1:0] r_haddr_0, r_haddr_1;
  logic [DataWidth-1:0] r_hwdata_0, r_hwdata_1;
  logic                 r_hwrite;
  logic                 w_trans_active;
  logic                 w_addr_in_range;

  // Free-running pipeline: the APB FSM picks the stage it needs, so no enable.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_haddr_0  <= '0;
      r_haddr_1  <= '0;
      r_hwdata_0 <= '0;
      r_hwdata_1 <= '0;
      r_hwrite   <= 1'b0;
    end else begin
      r_haddr_0  <= haddr;
      r_haddr_1  <= r_haddr_0;
      r_hwdata_0 <= hwdata;
      r_hwdata_1 <= r_hwdata_0;
      r_hwrite   <= hwrite;
    end
  end

  always_comb begin
    w_trans_active  = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    w_addr_in_range = (haddr >= SLV0_BASE) && (haddr < SLV_END);
    valid           = hresetn && hready_in && w_trans_active && w_addr_in_range;
  end

  bridge_addr_decode u_addr_decode (
    .i_haddr (haddr),
    .o_sel   (temp_sel)
  );

  assign haddr_0    = r_haddr_0;
  assign haddr_1    = r_haddr_1;
  assign hwdata_0   = r_hwdata_0;
  assign hwdata_1   = r_hwdata_1;
  assign hwrite_reg = r_hwrite;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed self-checking bench for ahb_slave_interface.
module tb_ahb_slave_interface;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        valid;
  logic [31:0] haddr_0, haddr_1, hwdata_0, hwdata_1;
  logic        hwrite_reg;
  logic [2:0]  temp_sel;

  int errors = 0;
  int checks = 0;

  ahb_slave_interface dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hwrite     (hwrite),
    .hready_in  (hready_in),
    .htrans     (htrans),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .valid      (valid),
    .haddr_0    (haddr_0),
    .haddr_1    (haddr_1),
    .hwdata_0   (hwdata_0),
    .hwdata_1   (hwdata_1),
    .hwrite_reg (hwrite_reg),
    .temp_sel   (temp_sel)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic test_reset();
    hresetn   = 1'b0;
    hready_in = 1'b1;
    htrans    = 2'b11;
    hwrite    = 1'b0;
    haddr     = '0;
    hwdata    = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      haddr  = $urandom();
      hwdata = $urandom();
      hwrite = 1'($urandom());
    end
    @(negedge hclk);
    haddr  = 32'h8140_1C85;
    hwdata = 32'hDEAD_BEEF;
    hwrite = 1'b1;
    @(posedge hclk);
    #1;
    checks++;
    if (haddr_0 !== 32'h0) begin
      errors++; $display("FAIL reset_haddr_0 got=%h exp=%h", haddr_0, 32'h0);
    end
    checks++;
    if (haddr_1 !== 32'h0) begin
      errors++; $display("FAIL reset_haddr_1 got=%h exp=%h", haddr_1, 32'h0);
    end
    checks++;
    if (hwdata_0 !== 32'h0) begin
      errors++; $display("FAIL reset_hwdata_0 got=%h exp=%h", hwdata_0, 32'h0);
    end
    checks++;
    if (hwdata_1 !== 32'h0) begin
      errors++; $display("FAIL reset_hwdata_1 got=%h exp=%h", hwdata_1, 32'h0);
    end
    checks++;
    if (hwrite_reg !== 1'b0) begin
      errors++; $display("FAIL reset_hwrite_reg got=%b exp=0", hwrite_reg);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", valid);
    end
    checks++;
    if (temp_sel !== 3'b001) begin
      errors++; $display("FAIL reset_temp_sel got=%b exp=001", temp_sel);
    end
  endtask

  task automatic test_pipeline();
    logic [31:0] vec [4] = '{32'h8140_1C85, 32'h8440_1C85, 32'h8840_1C85, 32'h8C40_1C85};
    logic        wr  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp1;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      hresetn = 1'b1;
      hwrite  = wr[i];
      haddr   = vec[i];
      hwdata  = vec[i];
      @(posedge hclk);
      #1;
      exp1 = (i == 0) ? 32'h0 : vec[(i == 0) ? 0 : i - 1];
      checks++;
      if (haddr_0 !== vec[i]) begin
        errors++; $display("FAIL pipe%0d_haddr_0 got=%h exp=%h", i, haddr_0, vec[i]);
      end
      checks++;
      if (haddr_1 !== exp1) begin
        errors++; $display("FAIL pipe%0d_haddr_1 got=%h exp=%h", i, haddr_1, exp1);
      end
      checks++;
      if (hwdata_0 !== vec[i]) begin
        errors++; $display("FAIL pipe%0d_hwdata_0 got=%h exp=%h", i, hwdata_0, vec[i]);
      end
      checks++;
      if (hwdata_1 !== exp1) begin
        errors++; $display("FAIL pipe%0d_hwdata_1 got=%h exp=%h", i, hwdata_1, exp1);
      end
      checks++;
      if (hwrite_reg !== wr[i]) begin
        errors++; $display("FAIL pipe%0d_hwrite_reg got=%b exp=%b", i, hwrite_reg, wr[i]);
      end
    end
  endtask

  // Shared by decode and boundary tables: htrans SEQ, hready_in high.
  task automatic test_decode();
    logic [31:0] addr [11] = '{32'h8140_1C85, 32'h8440_1C85, 32'h8840_1C85, 32'h8C40_1C85,
                               32'hBF14_1C85, 32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF,
                               32'h8400_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
    logic [2:0]  sel  [11] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b001,
                               3'b001, 3'b010, 3'b100, 3'b000};
    logic        vld  [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge hclk);
      hready_in = 1'b1;
      htrans    = 2'b11;
      haddr     = addr[i];
      #1;
      checks++;
      if (temp_sel !== sel[i]) begin
        errors++; $display("FAIL decode_sel addr=%h got=%b exp=%b", addr[i], temp_sel, sel[i]);
      end
      checks++;
      if (valid !== vld[i]) begin
        errors++; $display("FAIL decode_valid addr=%h got=%b exp=%b", addr[i], valid, vld[i]);
      end
    end
  endtask

  task automatic test_qualification();
    logic [1:0] tr  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic       rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vld [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      haddr     = 32'h8140_1C85;
      htrans    = tr[i];
      hready_in = rdy[i];
      #1;
      checks++;
      if (valid !== vld[i]) begin
        errors++;
        $display("FAIL qual_valid htrans=%b hready=%b got=%b exp=%b", tr[i], rdy[i], valid,
                 vld[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge hclk);
    hready_in = 1'b1;
    htrans    = 2'b10;
    hwrite    = 1'b1;
    haddr     = 32'h8440_1C85;
    hwdata    = 32'hA5A5_5A5A;
    @(posedge hclk);
    @(posedge hclk);
    #2;
    checks++;
    if (haddr_1 !== 32'h8440_1C85 || valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre haddr_1=%h valid=%b exp=%h/1", haddr_1, valid, 32'h8440_1C85);
    end
    hresetn = 1'b0;
    #1;
    checks++;
    if (haddr_0 !== 32'h0 || haddr_1 !== 32'h0) begin
      errors++; $display("FAIL async_haddr got=%h/%h exp=0/0", haddr_0, haddr_1);
    end
    checks++;
    if (hwdata_0 !== 32'h0 || hwdata_1 !== 32'h0) begin
      errors++; $display("FAIL async_hwdata got=%h/%h exp=0/0", hwdata_0, hwdata_1);
    end
    checks++;
    if (hwrite_reg !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL async_ctrl hwrite_reg=%b valid=%b exp=0/0", hwrite_reg, valid);
    end
    @(posedge hclk);
    #1;
    checks++;
    if (haddr_0 !== 32'h0 || hwdata_0 !== 32'h0) begin
      errors++; $display("FAIL async_hold got=%h/%h exp=0/0", haddr_0, hwdata_0);
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_decode();
    test_qualification();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
